// File: rtl/histo_th_engine.sv
// Frame-based depth histogram and threshold engine.
// Accumulates width*height depth samples into 2**P_BIN_BIT bins, then walks
// the bins once (one bin per cycle) to place up to P_TH_NUM thresholds, either
// at equal-count quantiles (mode 0) or at equal-range bin boundaries (mode 1).
module histo_th_engine #(
    parameter int P_DEPTH_BIT  = 8,
    parameter int P_BIN_BIT    = 4,
    parameter int P_TH_NUM     = 4,
    parameter int P_WIDTH_BIT  = 10,
    parameter int P_HEIGHT_BIT = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [P_WIDTH_BIT-1:0]          width,
    input  logic [P_HEIGHT_BIT-1:0]         height,
    input  logic [$clog2(P_TH_NUM+1)-1:0]   th_num,
    input  logic                            mode,
    input  logic                            frame_start,
    input  logic                            xds_in_valid,
    output logic                            xds_in_ready,
    input  logic [P_DEPTH_BIT-1:0]          depth,
    output logic                            xds_out_valid,
    input  logic                            xds_out_ready,
    output logic [P_TH_NUM*P_DEPTH_BIT-1:0] histo_th,
    output logic                            frame_finish,
    output logic                            busy
);

    localparam int HISTO_SIZE = 1 << P_BIN_BIT;
    localparam int SHIFT      = P_DEPTH_BIT - P_BIN_BIT;
    localparam int N_W        = P_WIDTH_BIT + P_HEIGHT_BIT;
    localparam int TN_W       = $clog2(P_TH_NUM + 1);
    localparam int TOP_W      = P_DEPTH_BIT + 1;
    // Wide enough for cum*(th_num+1), k*N, (b+1)*(th_num+1) and k*HISTO_SIZE.
    localparam int CMP_BASE   = (N_W > P_BIN_BIT + 1) ? N_W : P_BIN_BIT + 1;
    localparam int CMP_W      = CMP_BASE + TN_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_SCAN,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    // Frame configuration latched at frame_start.
    logic [N_W-1:0]  n_q;
    logic [TN_W-1:0] th_num_q;
    logic            mode_q;

    // Accumulation.
    logic [N_W-1:0]       count_q;
    logic [N_W-1:0]       bins_q [HISTO_SIZE];
    logic [N_W-1:0]       n_new;
    logic [TN_W-1:0]      th_num_clamp;
    logic [TN_W-1:0]      th_num_eff;
    logic [P_BIN_BIT-1:0] in_bin;
    logic                 in_hs;

    // Scan.
    logic [P_BIN_BIT-1:0]                    idx_q;
    logic [N_W-1:0]                          cum_q, cum_d;
    logic [P_TH_NUM-1:0]                     done_q;
    logic [P_TH_NUM-1:0][P_DEPTH_BIT-1:0]    th_q;
    logic [P_TH_NUM-1:0]                     hit;
    logic [CMP_W-1:0]                        tn_plus1, lhs_cnt, lhs_rng;
    logic [P_DEPTH_BIT-1:0]                  bin_top;
    logic                                    last_bin;
    logic                                    scan_enter;

    logic frame_finish_q;

    assign n_new        = N_W'(width) * N_W'(height);
    assign in_bin       = P_BIN_BIT'(depth >> SHIFT);
    assign xds_in_ready = (state_q == S_ACCUM) && (count_q != n_q);
    assign in_hs        = xds_in_ready && xds_in_valid;
    assign th_num_eff   = (state_q == S_IDLE) ? th_num_clamp : th_num_q;
    assign scan_enter   = (state_q != S_SCAN) && (state_d == S_SCAN);

    assign xds_out_valid = (state_q == S_OUT);
    assign histo_th      = th_q;
    assign frame_finish  = frame_finish_q;
    assign busy          = (state_q != S_IDLE);

    // Requested threshold count: 0 means one threshold, excess is clamped.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        th_num_clamp = th_num;
        if (th_num == '0) begin
            th_num_clamp = TN_W'(1);
        end else if (th_num > TN_W'(P_TH_NUM)) begin
            th_num_clamp = TN_W'(P_TH_NUM);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (frame_start) state_d = (n_new == '0) ? S_SCAN : S_ACCUM;
            S_ACCUM: if (count_q == n_q) state_d = S_SCAN;
            S_SCAN:  if (last_bin) state_d = S_OUT;
            S_OUT:   if (xds_out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Configuration latch, sample counter and histogram bins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q      <= '0;
            th_num_q <= '0;
            mode_q   <= 1'b0;
            count_q  <= '0;
            // NOTE: the bins are flops, not a RAM, so clearing them on reset and per frame is legal.
            for (int b = 0; b < HISTO_SIZE; b++) bins_q[b] <= '0;
        end else if (state_q == S_IDLE && frame_start) begin
            n_q      <= n_new;
            th_num_q <= th_num_clamp;
            mode_q   <= mode;
            count_q  <= '0;
            for (int b = 0; b < HISTO_SIZE; b++) bins_q[b] <= '0;
        end else if (in_hs) begin
            count_q        <= count_q + N_W'(1);
            bins_q[in_bin] <= bins_q[in_bin] + N_W'(1);
        end
    end

    // Threshold tests for the bin currently being visited.
    always_comb begin
        cum_d    = cum_q + bins_q[idx_q];
        last_bin = (idx_q == P_BIN_BIT'(HISTO_SIZE - 1));
        tn_plus1 = CMP_W'(th_num_q) + CMP_W'(1);
        lhs_cnt  = CMP_W'(cum_d) * tn_plus1;
        lhs_rng  = (CMP_W'(idx_q) + CMP_W'(1)) * tn_plus1;
        // Top depth value covered by this bin: ((b+1) << S) - 1.
        bin_top  = P_DEPTH_BIT'(((TOP_W'(idx_q) + TOP_W'(1)) << SHIFT) - TOP_W'(1));
        hit      = '0;
        for (int k = 0; k < P_TH_NUM; k++) begin
            if (mode_q) hit[k] = lhs_rng >= (CMP_W'(k + 1) << P_BIN_BIT);
            else        hit[k] = lhs_cnt >= CMP_W'(k + 1) * CMP_W'(n_q);
        end
    end

    // Scan walk: slots are armed on scan entry and each claims the first bin that satisfies it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            cum_q  <= '0;
            done_q <= '0;
            th_q   <= '0;
        end else if (scan_enter) begin
            idx_q <= '0;
            cum_q <= '0;
            for (int k = 0; k < P_TH_NUM; k++) begin
                if (TN_W'(k) < th_num_eff) begin
                    done_q[k] <= 1'b0;
                    th_q[k]   <= '0;
                end else begin
                    done_q[k] <= 1'b1;
                    th_q[k]   <= '1;
                end
            end
        end else if (state_q == S_SCAN) begin
            idx_q <= idx_q + P_BIN_BIT'(1);
            cum_q <= cum_d;
            for (int k = 0; k < P_TH_NUM; k++) begin
                if (!done_q[k]) begin
                    if (hit[k]) begin
                        th_q[k]   <= bin_top;
                        done_q[k] <= 1'b1;
                    end else if (last_bin) begin
                        th_q[k]   <= '1;
                        done_q[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // One-cycle frame_finish pulse following the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_finish_q <= 1'b0;
        else     frame_finish_q <= (state_q == S_OUT) && xds_out_ready;
    end

endmodule
